// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the run-control sequencer: state encoding and default widths.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    localparam int EXEC_DIV_W = 23;
    localparam int EXEC_DB_W  = 20;
    localparam int EXEC_PC_W  = 32;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse.
// Press pulse appears 2 + 2^DB_W cycles after the key settles low; holding the key never repeats it.
module key_debounce
    import exec_ctrl_pkg::*;
#(
    parameter int DB_W = EXEC_DB_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            // Any bounce back to the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (&cnt) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + {{(DB_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/exec_step_ctrl.sv
// Run-control sequencer: halt / single-step / divided free-run / PC breakpoint, driving pipe_en.
// pipe_en is registered one cycle after the advance condition; stall_in suppresses (and in RUN drops) an advance.
module exec_step_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int DIV_W = EXEC_DIV_W,
    parameter int DB_W  = EXEC_DB_W,
    parameter int PC_W  = EXEC_PC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_step_n,
    input  logic            key_run_n,
    input  logic            stall_in,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    output logic            pipe_en,
    output logic            halted,
    output logic [1:0]      state,
    output logic [31:0]     instr_count
);

    state_t           state_q;
    state_t           state_d;
    logic             step_p;
    logic             run_p;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic             bp_skip_q;
    logic             bp_hit;
    logic             adv_req;
    logic             issue;
    logic [31:0]      instr_count_q;

    key_debounce #(.DB_W(DB_W)) u_step_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_step_n),
        .press (step_p)
    );

    key_debounce #(.DB_W(DB_W)) u_run_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_run_n),
        .press (run_p)
    );

    assign tick   = &div_q;
    assign bp_hit = bp_en & (pc == bp_addr) & ~bp_skip_q & (state_q == ST_RUN);
    assign issue  = adv_req & ~stall_in & ~bp_hit;

    always_comb begin
        state_d = state_q;
        adv_req = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (run_p)       state_d = ST_RUN;
                else if (step_p) state_d = ST_STEP;
            end
            ST_STEP: begin
                // bp_hit is never set outside RUN, so only the stall holds a step back.
                if (run_p) begin
                    state_d = ST_HALT;
                end else begin
                    adv_req = 1'b1;
                    if (!stall_in) state_d = ST_HALT;
                end
            end
            ST_RUN: begin
                if (run_p) begin
                    state_d = ST_HALT;
                end else if (tick) begin
                    adv_req = 1'b1;
                    if (bp_hit) state_d = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (run_p)       state_d = ST_RUN;
                else if (step_p) state_d = ST_STEP;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HALT;
            pipe_en       <= 1'b0;
            div_q         <= '0;
            bp_skip_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            pipe_en <= issue;
            if (pipe_en) instr_count_q <= instr_count_q + 32'd1;
            if (state_d == ST_RUN && state_q != ST_RUN) div_q <= '0;
            else if (state_q == ST_RUN)                 div_q <= div_q + {{(DIV_W-1){1'b0}}, 1'b1};
            // Leaving BREAK lets the first advance step past the PC that just matched.
            if (state_q == ST_BREAK && state_d != ST_BREAK) bp_skip_q <= 1'b1;
            else if (issue)                                 bp_skip_q <= 1'b0;
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == ST_HALT) | (state_q == ST_BREAK);
    assign instr_count = instr_count_q;

endmodule
